// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: a fetch-PC register driving imem plus a DEPTH-entry prefetch queue.
// A redirect flushes the queue and restarts fetch at the word-aligned target.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_instr,
    output logic [XLEN-1:0]            out_pc_plus4,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  fetch_pc_plus4;
    logic [XLEN-1:0]  instr_q [DEPTH];
    logic [XLEN-1:0]  pcp4_q  [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign fetch_pc_plus4 = fetch_pc + XLEN'(4);
    assign imem_addr      = fetch_pc;
    assign occupancy      = count;

    // A redirect kills the head combinationally so decode never consumes a stale instruction.
    assign out_valid    = !redirect_valid && (count != '0);
    assign out_instr    = instr_q[head];
    assign out_pc_plus4 = pcp4_q[head];

    assign pop  = out_valid && out_ready;
    assign push = !redirect_valid && ((count < DEPTH_C) || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pcp4_q[i]  <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                instr_q[tail] <= imem_rdata;
                pcp4_q[tail]  <= fetch_pc_plus4;
                tail          <= tail + PTR_W'(1);
                fetch_pc      <= fetch_pc_plus4;
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: imem returns address-tagged words, expectations hand-derived.
module tb_fetch_queue_unit;

    localparam logic [31:0] TAG = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus4;
    logic [2:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc_plus4   (out_pc_plus4),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ TAG;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        step();
        step();
        check("rst_occ",   32'(occupancy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_addr",  imem_addr,      32'h0);
        check("rst_instr", out_instr,      32'h0);
        check("rst_pcp4",  out_pc_plus4,   32'h0);

        // Streaming with decode always ready
        reset = 1'b0;
        #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        step();
        check("s1_valid", 32'(out_valid), 32'd1);
        check("s1_pcp4",  out_pc_plus4,   32'd4);
        check("s1_instr", out_instr,      32'h0 ^ TAG);
        step();
        check("s2_pcp4",  out_pc_plus4,   32'd8);
        check("s2_occ",   32'(occupancy), 32'd1);
        step();
        check("s3_pcp4",  out_pc_plus4,   32'd12);
        check("s3_instr", out_instr,      32'h8 ^ TAG);
        check("s3_addr",  imem_addr,      32'd12);

        // Stall fill from a fresh reset
        reset = 1'b1;
        step();
        reset     = 1'b0;
        out_ready = 1'b0;
        step();
        check("stall_early_pcp4", out_pc_plus4, 32'd4);
        for (int i = 0; i < 9; i++) step();
        check("stall_occ",   32'(occupancy), 32'd4);
        check("stall_addr",  imem_addr,      32'h10);
        check("stall_pcp4",  out_pc_plus4,   32'd4);
        check("stall_instr", out_instr,      32'h0 ^ TAG);
        check("stall_valid", 32'(out_valid), 32'd1);

        // Full queue, one simultaneous push+pop
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("full_pp_occ",  32'(occupancy), 32'd4);
        check("full_pp_pcp4", out_pc_plus4,   32'd8);
        check("full_pp_addr", imem_addr,      32'h14);

        // Redirect a full queue to 0x100, then fill three entries
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        out_ready      = 1'b1;
        #1;
        check("redir1_same_valid", 32'(out_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        check("redir1_occ",   32'(occupancy), 32'd0);
        check("redir1_addr",  imem_addr,      32'h100);
        check("redir1_valid", 32'(out_valid), 32'd0);
        step();
        step();
        step();
        check("fill3_occ",  32'(occupancy), 32'd3);
        check("fill3_pcp4", out_pc_plus4,   32'h104);
        check("fill3_addr", imem_addr,      32'h10C);

        // Misaligned redirect with three entries queued
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        out_ready      = 1'b1;
        #1;
        check("redir43_same_valid", 32'(out_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        check("redir43_occ",   32'(occupancy), 32'd0);
        check("redir43_addr",  imem_addr,      32'h40);
        check("redir43_valid", 32'(out_valid), 32'd0);
        step();
        check("redir43_head_valid", 32'(out_valid), 32'd1);
        check("redir43_head_pcp4",  out_pc_plus4,   32'h44);
        check("redir43_head_instr", out_instr,      32'h40 ^ TAG);
        check("redir43_head_occ",   32'(occupancy), 32'd1);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_pcp4",  out_pc_plus4, 32'h0);
        check("wrap_instr", out_instr,    32'hFFFF_FFFC ^ TAG);
        check("wrap_addr1", imem_addr,    32'h0);
        step();
        check("wrap_next_pcp4", out_pc_plus4, 32'h4);
        check("wrap_next_addr", imem_addr,    32'h4);

        // Fill, then reset and redirect together
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("prefull_occ", 32'(occupancy), 32'd4);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        check("rst_redir_occ",  32'(occupancy), 32'd0);
        check("rst_redir_addr", imem_addr,      32'h0);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("rst_redir_valid", 32'(out_valid),  32'd0);
        check("rst_redir_instr", out_instr,       32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC, instruction and address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries; power of two, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC loaded on reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port imem_addr, output, XLEN bits: fetch PC presented to instruction memory.
REQ-007 SHALL have port imem_rdata, input, XLEN bits: instruction at imem_addr, combinational same-cycle read.
REQ-008 SHALL have port redirect_valid, input, 1 bit: branch/jump taken, from a later stage.
REQ-009 SHALL have port redirect_pc, input, XLEN bits: branch target.
REQ-010 SHALL have port out_valid, output, 1 bit: queue head is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: decode accepts head (low = stall).
REQ-012 SHALL have port out_instr, output, XLEN bits: head instruction.
REQ-013 SHALL have port out_pc_plus4, output, XLEN bits: head PC + 4.
REQ-014 SHALL have port occupancy, output, clog2(DEPTH)+1 bits: current entry count.

Function
REQ-015 SHALL drive imem_addr from an internal fetch-PC register.
REQ-016 SHALL define pop as out_valid AND out_ready.
REQ-017 SHALL define push as NOT redirect_valid AND (occupancy < DEPTH OR pop).
- On push: write {fetch_pc+4, imem_rdata} at tail; fetch_pc <= fetch_pc+4.
REQ-018 SHALL leave fetch_pc unchanged when there is no push and no redirect.
REQ-019 SHALL, for simultaneous push and pop, keep occupancy unchanged and pop the head while writing the tail, including when the queue is full.
REQ-020 SHALL, on redirect_valid:
- flush all entries (occupancy <= 0, pointers reset);
- fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
- perform no push that cycle.
REQ-021 SHALL force out_valid low combinationally while redirect_valid is high, so no transfer completes in a redirect cycle.
REQ-022 SHALL otherwise drive out_valid = (occupancy != 0), with out_instr/out_pc_plus4 taken from the head entry.
REQ-023 SHALL give a first-instruction latency of one cycle: fetched in cycle N, presented at the head in cycle N+1.
REQ-024 SHALL give a sustained throughput of one instruction per cycle when out_ready is held high.
REQ-025 SHALL hold head outputs stable while out_valid=1 and out_ready=0.
REQ-026 SHALL wrap PC arithmetic modulo 2^XLEN (0xFFFFFFFC + 4 = 0); queue pointers wrap modulo DEPTH.
REQ-027 SHALL never let occupancy exceed DEPTH or go below 0.

Reset
REQ-028 SHALL, when reset is high at a clock edge, set fetch_pc <= RESET_PC and occupancy <= 0, and give reset priority over redirect and push.
REQ-029 SHALL hold out_valid=0 in the cycle after reset; out_instr/out_pc_plus4 are 0 after reset; imem_addr = RESET_PC.
REQ-030 SHALL, when reset is asserted mid-stream with a full queue, discard all entries within one cycle.

Verification
REQ-031 SHALL cover: reset, then out_ready=1, imem returning addr-tagged data -> out_valid rises one cycle after reset release; heads at pc_plus4 = 4, 8, 12, one per cycle.
REQ-032 SHALL cover: out_ready=0 for 10 cycles -> occupancy reaches 4 (DEPTH=4), imem_addr frozen at 0x10, head stable at pc_plus4=4.
REQ-033 SHALL cover: full queue with out_ready=1 for one cycle -> occupancy stays 4, head advances to pc_plus4=8, imem_addr = 0x14.
REQ-034 SHALL cover: redirect_valid=1, redirect_pc=0x43 with 3 entries -> same-cycle out_valid=0; next cycle occupancy 0, imem_addr=0x40; following cycle head pc_plus4=0x44.
REQ-035 SHALL cover: redirect to 0xFFFFFFFC -> head pc_plus4=0, next fetch at 0x0.
REQ-036 SHALL cover: reset and redirect both high -> fetch_pc = RESET_PC, queue empty.
